// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and the GF(2^8) doubling helper
// used by the key-expansion block.
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_KEY_W = 128;

   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] XTIME_POLY = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Multiply by x in GF(2^8), reduced by the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Entry 0 sits in the most significant byte of the literal
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX[a];

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key expansion: one round key per clock into an 11-entry store.
// Define AES_KEYEXP_ZEROIZE_EN to have Rst also clear the stored keys.
module aes_key_expansion
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NR,
   parameter int KEY_W      = AES_KEY_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic [KEY_W-1:0] Key,
   input  logic [3:0]       SelKey,
   output logic [KEY_W-1:0] RoundKey,
   output logic             Ry,
   output logic             Busy
);

   state_e           state, state_nxt;
   logic [3:0]       cnt;
   logic [7:0]       rcon;
   logic [KEY_W-1:0] w;
   logic [KEY_W-1:0] slot [NUM_ROUNDS+1];

   logic             start, expand, last;
   logic [31:0]      rot, sub, temp;
   logic [31:0]      w0, w1, w2, w3;
   logic [KEY_W-1:0] w_nxt;

   // En is only honoured outside EXPAND; a request mid-expansion is dropped
   assign start  = En && (state != ST_EXPAND);
   assign expand = (state == ST_EXPAND);
   assign last   = expand && (cnt == 4'(NUM_ROUNDS));

   always_ff @(posedge Clk) begin
      if (Rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (En)   state_nxt = ST_EXPAND;
         ST_EXPAND: if (last) state_nxt = ST_DONE;
         ST_DONE:   if (En)   state_nxt = ST_EXPAND;
         default:             state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      Ry   = (state == ST_DONE);
      Busy = (state == ST_EXPAND);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt  <= '0;
         rcon <= RCON_INIT;
      end else if (start) begin
         cnt  <= 4'd1;
         rcon <= RCON_INIT;
      end else if (expand) begin
         cnt  <= cnt + 4'd1;
         rcon <= xtime(rcon);
      end
   end

   // SubWord(RotWord(w3)): rotation moves the top byte to the bottom
   assign rot = {w[23:0], w[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .a (rot[8*g +: 8]),
         .y (sub[8*g +: 8])
      );
   end

   assign temp  = sub ^ {rcon, 24'h0};
   assign w0    = w[127:96] ^ temp;
   assign w1    = w[95:64]  ^ w0;
   assign w2    = w[63:32]  ^ w1;
   assign w3    = w[31:0]   ^ w2;
   assign w_nxt = {w0, w1, w2, w3};

   // Key store; without zeroize Rst only blocks writes, contents survive
   always_ff @(posedge Clk) begin
      if (Rst) begin
`ifdef AES_KEYEXP_ZEROIZE_EN
         w <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) slot[i] <= '0;
`endif
      end else if (start) begin
         w       <= Key;
         slot[0] <= Key;
      end else if (expand) begin
         w         <= w_nxt;
         slot[cnt] <= w_nxt;
      end
   end

   assign RoundKey = (SelKey <= 4'(NUM_ROUNDS)) ? slot[SelKey] : '0;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion using FIPS-197 A.1 and all-zero keys.
module tb_aes_key_expansion;

   localparam logic [127:0] K_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K_A1_1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K_A1_X = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K_Z_1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] K_Z_X  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
`ifdef AES_KEYEXP_ZEROIZE_EN
   localparam bit ZEROIZE = 1'b1;
`else
   localparam bit ZEROIZE = 1'b0;
`endif

   logic         Clk, Rst, En, Ry, Busy;
   logic [127:0] Key, RoundKey;
   logic [3:0]   SelKey;

   typedef struct {
      bit           chk_key;
      logic [3:0]   sel;
      logic [127:0] key;
      bit           ry;
      bit           busy;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   aes_key_expansion dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .En       (En),
      .Key      (Key),
      .SelKey   (SelKey),
      .RoundKey (RoundKey),
      .Ry       (Ry),
      .Busy     (Busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Monitor: each negedge consumes one expected response
   always @(negedge Clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (Ry !== e.ry) begin
            errors++;
            $display("FAIL ry: got %b want %b (t=%0t)", Ry, e.ry, $time);
         end
         checks++;
         if (Busy !== e.busy) begin
            errors++;
            $display("FAIL busy: got %b want %b (t=%0t)", Busy, e.busy, $time);
         end
         if (e.chk_key) begin
            checks++;
            if (RoundKey !== e.key) begin
               errors++;
               $display("FAIL roundkey[%0d]: got %h want %h", e.sel, RoundKey, e.key);
            end
         end
      end
   end

   task automatic push(input bit ck, input logic [3:0] s, input logic [127:0] k,
                       input bit ry, input bit busy);
      SelKey = s;
      q.push_back('{ck, s, k, ry, busy});
      @(negedge Clk); #1;
   endtask

   task automatic step(input bit ck, input logic [3:0] s, input logic [127:0] k,
                       input bit ry, input bit busy);
      @(posedge Clk); #1;
      push(ck, s, k, ry, busy);
   endtask

   // Drives En for the accepting edge and checks the first busy cycle
   task automatic start(input logic [127:0] k, input bit hold);
      @(posedge Clk); #1;
      En  = 1'b1;
      Key = k;
      @(posedge Clk); #1;
      En  = hold;
      push(0, 4'd0, '0, 0, 1);
   endtask

   // Full expansion: busy for 10 cycles, Ry after the 11th edge
   task automatic full_expand(input logic [127:0] k, input bit hold);
      start(k, hold);
      for (int i = 0; i < 9; i++) step(0, 4'd0, '0, 0, 1);
      step(1, 4'd0, k, 1, 0);
      En = 1'b0;
   endtask

   initial begin
      Rst = 1'b1; En = 1'b0; Key = '0; SelKey = '0;
      step(0, 4'd0, '0, 0, 0);
      step(ZEROIZE, 4'd0, '0, 0, 0);
      Rst = 1'b0;
      step(0, 4'd0, '0, 0, 0);

      // FIPS-197 A.1 key
      full_expand(K_A1, 0);
      push(1, 4'd1,  K_A1_1, 1, 0);
      push(1, 4'd10, K_A1_X, 1, 0);
      for (int s = 11; s < 16; s++) push(1, 4'(s), '0, 1, 0);

      // Abort four cycles after the accepting edge
      start(K_A1, 0);
      for (int i = 0; i < 3; i++) step(0, 4'd0, '0, 0, 1);
      Rst = 1'b1;
      step(0, 4'd0, '0, 0, 0);
      Rst = 1'b0;
      step(0, 4'd0, '0, 0, 0);
      full_expand(K_A1, 0);
      push(1, 4'd10, K_A1_X, 1, 0);

      // En held through EXPAND, then a restart from DONE with the zero key
      full_expand(K_A1, 1);
      push(1, 4'd10, K_A1_X, 1, 0);
      full_expand('0, 0);
      push(1, 4'd1,  K_Z_1, 1, 0);
      push(1, 4'd10, K_Z_X, 1, 0);

      // Reset after a completed expansion: store contents depend on zeroize
      full_expand(K_A1, 0);
      push(1, 4'd10, K_A1_X, 1, 0);
      Rst = 1'b1;
      step(1, 4'd10, ZEROIZE ? 128'h0 : K_A1_X, 0, 0);
      Rst = 1'b0;
      step(0, 4'd0, '0, 0, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clk);
      #1;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d responses pending, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
